rtc_i2c_sched: RTL and testbench

Transaction scheduler for the PCF8563 RTC on the shared I2C bus. It sits between the host-side RTC interface (get/set requests, 56-bit time word) and a byte-level I2C engine. It arbitrates a periodic poll timer, explicit get requests and set requests. It expands each request into an ordered script of byte commands, checks ACKs, retries failed transactions, and publishes the time word atomically.

---
 rtl/rtc_i2c_sched_if.sv | 14 +
 rtl/rtc_i2c_sched.sv | 196 +++++++++++++++++++
 tb/tb_rtc_i2c_sched.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_i2c_sched_if.sv
// Byte-command channel between the RTC scheduler (master) and the I2C byte engine (slave).
interface rtc_i2c_sched_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       cmd_done;
  logic [7:0] cmd_rdata;
  logic       cmd_nack;

  modport master (output cmd_valid, cmd_op, cmd_wdata,
                  input  cmd_done, cmd_rdata, cmd_nack);
  modport slave  (input  cmd_valid, cmd_op, cmd_wdata,
                  output cmd_done, cmd_rdata, cmd_nack);
endinterface

// File: rtl/rtc_i2c_sched.sv
// PCF8563 transaction scheduler: turns poll/get/set requests into I2C byte-command scripts.
// S_IDLE | pick set (priority) or get request | S_ISSUE | strobe current step | S_WAIT | await done
// S_ABORT | strobe STOP after NACK | S_ABORT_WAIT | await STOP done, then retry or give up
module rtc_i2c_sched #(
  parameter logic [23:0] POLL_DIV  = 24'd5000000,
  parameter logic [7:0]  DEV_WR    = 8'hA2,
  parameter logic [7:0]  DEV_RD    = 8'hA3,
  parameter logic [7:0]  REG_BASE  = 8'h02,
  parameter int unsigned RETRY_MAX = 2
) (
  input  logic           i_mclk,
  input  logic           i_reset,
  input  logic           i_rtc_get,
  input  logic           i_rtc_set,
  input  logic [55:0]    i_rtc_in,
  output logic [55:0]    o_rtc,
  output logic           o_rtc_valid,
  output logic           o_busy,
  output logic           o_err,
  rtc_i2c_sched_if.master cmd
);
  localparam logic [2:0] OP_START = 3'd0, OP_STOP = 3'd1, OP_WRITE = 3'd2,
                         OP_RACK  = 3'd3, OP_RNACK = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT, S_ABORT_WAIT} state_t;
  state_t r_state, w_next;

  logic        r_get_q, r_set_q, r_get_pend, r_set_pend, r_is_wr;
  logic [23:0] r_poll_cnt;
  logic [55:0] r_shadow, r_stage, r_rtc;
  logic [3:0]  r_step;
  logic [2:0]  r_retry;
  logic        r_rtc_valid, r_err;

  logic        w_get_edge, w_set_edge, w_poll_hit, w_start, w_start_wr, w_set_busy;
  logic        w_adv, w_finish, w_restart, w_fail, w_store, w_valid, w_last;
  logic [2:0]  w_op;
  logic [7:0]  w_wdata;
  logic [6:0]  w_shift;
  logic [55:0] w_sh;

  assign w_get_edge = i_rtc_get & ~r_get_q;
  assign w_set_edge = i_rtc_set & ~r_set_q;
  assign w_poll_hit = (r_poll_cnt == POLL_DIV - 24'd1);
  assign w_start_wr = w_start & r_set_pend;
  // The start cycle counts as "write running" so a late edge cannot swap bytes under it.
  assign w_set_busy = ((r_state != S_IDLE) & r_is_wr) | w_start_wr;

  always_comb begin
    w_op    = OP_STOP;
    w_wdata = 8'h00;
    w_last  = 1'b0;
    w_shift = {r_step - 4'd3, 3'b000};
    w_sh    = r_shadow << w_shift;
    if (r_is_wr) begin
      w_last = (r_step == 4'd10);
      case (r_step)
        4'd0:    w_op = OP_START;
        4'd1:    begin w_op = OP_WRITE; w_wdata = DEV_WR;   end
        4'd2:    begin w_op = OP_WRITE; w_wdata = REG_BASE; end
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                 begin w_op = OP_WRITE; w_wdata = w_sh[55:48]; end
        default: w_op = OP_STOP;
      endcase
    end else begin
      w_last = (r_step == 4'd12);
      case (r_step)
        4'd0, 4'd3: w_op = OP_START;
        4'd1:    begin w_op = OP_WRITE; w_wdata = DEV_WR;   end
        4'd2:    begin w_op = OP_WRITE; w_wdata = REG_BASE; end
        4'd4:    begin w_op = OP_WRITE; w_wdata = DEV_RD;   end
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: w_op = OP_RACK;
        4'd11:   w_op = OP_RNACK;
        default: w_op = OP_STOP;
      endcase
    end
  end

  always_ff @(posedge i_mclk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_adv     = 1'b0;
    w_finish  = 1'b0;
    w_restart = 1'b0;
    w_fail    = 1'b0;
    w_store   = 1'b0;
    w_valid   = 1'b0;
    case (r_state)
      S_IDLE: if (r_set_pend || r_get_pend) begin
        w_start = 1'b1;
        w_next  = S_ISSUE;
      end
      S_ISSUE: begin
        w_valid = 1'b1;
        w_next  = S_WAIT;
      end
      S_WAIT: if (cmd.cmd_done) begin
        if (w_op == OP_WRITE && cmd.cmd_nack) begin
          w_next = S_ABORT;
        end else begin
          w_store = (w_op == OP_RACK) || (w_op == OP_RNACK);
          if (w_last) begin
            w_finish = 1'b1;
            w_next   = S_IDLE;
          end else begin
            w_adv  = 1'b1;
            w_next = S_ISSUE;
          end
        end
      end
      S_ABORT: begin
        w_valid = 1'b1;
        w_next  = S_ABORT_WAIT;
      end
      S_ABORT_WAIT: if (cmd.cmd_done) begin
        if (r_retry < 3'(RETRY_MAX)) begin
          w_restart = 1'b1;
          w_next    = S_ISSUE;
        end else begin
          w_fail = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_mclk or negedge i_reset) begin
    if (!i_reset) begin
      r_get_q     <= 1'b0;
      r_set_q     <= 1'b0;
      r_poll_cnt  <= 24'd0;
      r_get_pend  <= 1'b0;
      r_set_pend  <= 1'b0;
      r_shadow    <= 56'h0;
      r_is_wr     <= 1'b0;
      r_step      <= 4'd0;
      r_retry     <= 3'd0;
      r_stage     <= 56'h0;
      r_rtc       <= 56'h0;
      r_rtc_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_get_q    <= i_rtc_get;
      r_set_q    <= i_rtc_set;
      r_poll_cnt <= w_poll_hit ? 24'd0 : r_poll_cnt + 24'd1;

      if (w_set_edge && !w_set_busy) begin
        r_set_pend <= 1'b1;
        r_shadow   <= i_rtc_in;
      end else if (w_start_wr) begin
        r_set_pend <= 1'b0;
      end

      if (w_get_edge || w_poll_hit)   r_get_pend <= 1'b1;
      else if (w_start && !r_set_pend) r_get_pend <= 1'b0;

      if (w_start) begin
        r_is_wr <= r_set_pend;
        r_step  <= 4'd0;
        r_retry <= 3'd0;
      end
      if (w_adv) r_step <= r_step + 4'd1;
      if (w_restart) begin
        r_step  <= 4'd0;
        r_retry <= r_retry + 3'd1;
      end
      // Read bytes arrive sec first, so shifting in leaves sec in the top byte.
      if (w_store) r_stage <= {r_stage[47:0], cmd.cmd_rdata};
      if (w_finish) begin
        r_err <= 1'b0;
        if (!r_is_wr) begin
          r_rtc       <= r_stage;
          r_rtc_valid <= 1'b1;
        end
      end
      if (w_fail) begin
        r_err   <= 1'b1;
        r_retry <= 3'd0;
      end
    end
  end

  assign cmd.cmd_valid = w_valid;
  assign cmd.cmd_op    = (r_state == S_ABORT) ? OP_STOP : w_op;
  assign cmd.cmd_wdata = w_wdata;
  assign o_rtc         = r_rtc;
  assign o_rtc_valid   = r_rtc_valid;
  assign o_busy        = (r_state != S_IDLE);
  assign o_err         = r_err;
endmodule

// File: tb/tb_rtc_i2c_sched.sv
// Scoreboarded bench: expected command scripts are queued per request and matched at each strobe.
module tb_rtc_i2c_sched;
  localparam logic [23:0] POLL_DIV = 24'd600;
  localparam logic [2:0] OP_START = 3'd0, OP_STOP = 3'd1, OP_WRITE = 3'd2,
                         OP_RACK  = 3'd3, OP_RNACK = 3'd4;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rtc_get = 1'b0, rtc_set = 1'b0;
  logic [55:0] rtc_in = 56'h0;
  logic [55:0] rtc;
  logic        rtc_valid, busy, err;

  rtc_i2c_sched_if bus();

  rtc_i2c_sched #(.POLL_DIV(POLL_DIV)) dut (
    .i_mclk(mclk), .i_reset(reset_n), .i_rtc_get(rtc_get), .i_rtc_set(rtc_set),
    .i_rtc_in(rtc_in), .o_rtc(rtc), .o_rtc_valid(rtc_valid), .o_busy(busy),
    .o_err(err), .cmd(bus)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {logic [2:0] op; logic [7:0] data;} exp_t;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0, n_strobe = 0, n_rnack = 0;
  logic [7:0] rd_tab [7];
  int rd_idx = 0;
  bit nack_a2 = 1'b0;

  // Engine model: 3-cycle done latency, monitor pops the scoreboard on every strobe.
  initial begin
    logic [2:0] op_s;
    logic [7:0] d_s;
    exp_t e;
    bus.cmd_done = 1'b0; bus.cmd_rdata = 8'h00; bus.cmd_nack = 1'b0;
    #1;
    forever begin
      if (bus.cmd_valid === 1'b1) begin
        op_s = bus.cmd_op; d_s = bus.cmd_wdata;
        n_strobe++;
        if (op_s == OP_RNACK) n_rnack++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL cmd_unexpected: got op=%0d data=%02h, required no command", op_s, d_s);
        end else begin
          e = exp_q.pop_front();
          if (op_s !== e.op || (op_s == OP_WRITE && d_s !== e.data)) begin
            n_err++;
            $display("FAIL cmd_seq: got op=%0d data=%02h, required op=%0d data=%02h",
                     op_s, d_s, e.op, e.data);
          end
        end
        if (op_s == OP_WRITE && d_s == 8'hA3) rd_idx = 0;
        repeat (3) @(posedge mclk);
        #1;
        bus.cmd_done = 1'b1;
        bus.cmd_nack = (op_s == OP_WRITE && d_s == 8'hA2 && nack_a2);
        if ((op_s == OP_RACK || op_s == OP_RNACK) && rd_idx < 7) begin
          bus.cmd_rdata = rd_tab[rd_idx];
          rd_idx++;
        end
        @(posedge mclk);
        #1;
        bus.cmd_done = 1'b0; bus.cmd_nack = 1'b0;
      end else begin
        @(posedge mclk);
        #1;
      end
    end
  end

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] d);
    exp_t e;
    e.op = op; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_write(input logic [55:0] t);
    push_cmd(OP_START, 8'h00);
    push_cmd(OP_WRITE, 8'hA2);
    push_cmd(OP_WRITE, 8'h02);
    for (int i = 0; i < 7; i++) push_cmd(OP_WRITE, t[55-8*i -: 8]);
    push_cmd(OP_STOP, 8'h00);
  endtask

  task automatic push_read(input int n);
    for (int s = 0; s < n; s++) begin
      case (s)
        0, 3:    push_cmd(OP_START, 8'h00);
        1:       push_cmd(OP_WRITE, 8'hA2);
        2:       push_cmd(OP_WRITE, 8'h02);
        4:       push_cmd(OP_WRITE, 8'hA3);
        11:      push_cmd(OP_RNACK, 8'h00);
        12:      push_cmd(OP_STOP, 8'h00);
        default: push_cmd(OP_RACK, 8'h00);
      endcase
    end
  endtask

  task automatic set_table(input logic [55:0] t);
    for (int i = 0; i < 7; i++) rd_tab[i] = t[55-8*i -: 8];
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (4) @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
  endtask

  task automatic pulse(input bit do_get, input bit do_set);
    @(negedge mclk);
    rtc_get = do_get; rtc_set = do_set;
    repeat (2) @(negedge mclk);
    rtc_get = 1'b0; rtc_set = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int gap, output bit tmo);
    bit seen;
    seen = 1'b0; gap = 0; tmo = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge mclk);
      #1;
      if (busy) seen = 1'b1;
      else if (seen && exp_q.size() != 0) gap++;
      if (seen && !busy && exp_q.size() == 0) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge mclk);
    n_vec++; if (rtc !== 56'h0) begin n_err++; $display("FAIL reset_rtc: got %h, required 0", rtc); end
    n_vec++; if (rtc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", rtc_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, required 0", err); end
    n_vec++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_cmd_valid: got %b, required 0", bus.cmd_valid); end
  endtask

  task automatic test_poll_read();
    int cyc, gap, base, rb;
    bit tmo;
    set_table(56'h00592303060110);
    do_reset();
    push_read(13);
    base = n_strobe; rb = n_rnack; cyc = -1;
    for (int c = 1; c <= int'(POLL_DIV) + 20; c++) begin
      @(posedge mclk);
      #1;
      if (bus.cmd_valid === 1'b1) begin cyc = c; break; end
    end
    n_vec++; if (cyc != int'(POLL_DIV) + 1) begin n_err++; $display("FAIL poll_first_cycle: got %0d, required %0d", cyc, int'(POLL_DIV) + 1); end
    run_until_done(200, gap, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL poll_timeout: got timeout, required completion"); end
    n_vec++; if (rtc !== 56'h00592303060110) begin n_err++; $display("FAIL poll_rtc: got %h, required 00592303060110", rtc); end
    n_vec++; if (rtc_valid !== 1'b1) begin n_err++; $display("FAIL poll_valid: got %b, required 1", rtc_valid); end
    n_vec++; if (n_strobe - base != 13) begin n_err++; $display("FAIL poll_strobes: got %0d, required 13", n_strobe - base); end
    n_vec++; if (n_rnack - rb != 1) begin n_err++; $display("FAIL poll_read_nack: got %0d, required 1", n_rnack - rb); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL poll_err: got %b, required 0", err); end
  endtask

  task automatic test_set_write();
    logic [55:0] prev;
    int gap, base;
    bit tmo;
    prev = rtc; base = n_strobe;
    push_write(56'h30152112050324);
    rtc_in = 56'h30152112050324;
    pulse(1'b0, 1'b1);
    run_until_done(300, gap, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL set_timeout: got timeout, required completion"); end
    n_vec++; if (rtc !== prev) begin n_err++; $display("FAIL set_rtc_held: got %h, required %h", rtc, prev); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL set_busy: got %b, required 0", busy); end
    n_vec++; if (n_strobe - base != 11) begin n_err++; $display("FAIL set_strobes: got %0d, required 11", n_strobe - base); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL set_queue: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] a;
    int gap, base;
    bit tmo, hit;
    a = 56'h58472319061299;
    set_table(a);
    push_write(a);
    push_read(13);
    base = n_strobe;
    rtc_in = a;
    pulse(1'b1, 1'b1);
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge mclk);
      #1;
      if (n_strobe - base >= 5) begin hit = 1'b1; break; end
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL b2b_midwrite_wait: got timeout, required 5 strobes"); end
    rtc_in = 56'h01020304050607;
    pulse(1'b0, 1'b1);
    run_until_done(500, gap, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL b2b_timeout: got timeout, required completion"); end
    n_vec++; if (gap != 1) begin n_err++; $display("FAIL b2b_idle_gap: got %0d, required 1", gap); end
    n_vec++; if (rtc !== a) begin n_err++; $display("FAIL b2b_rtc: got %h, required %h", rtc, a); end
    repeat (30) @(posedge mclk);
    #1;
    n_vec++; if (n_strobe - base != 24) begin n_err++; $display("FAIL b2b_strobes: got %0d, required 24", n_strobe - base); end
  endtask

  task automatic test_poll_again();
    int gap;
    bit tmo;
    set_table(56'h15301004020525);
    push_read(13);
    run_until_done(int'(POLL_DIV) + 300, gap, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL poll2_timeout: got timeout, required completion"); end
    n_vec++; if (rtc !== 56'h15301004020525) begin n_err++; $display("FAIL poll2_rtc: got %h, required 15301004020525", rtc); end
  endtask

  task automatic test_nack_retry();
    logic [55:0] prev;
    int gap, base;
    bit tmo;
    prev = rtc; base = n_strobe;
    nack_a2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_cmd(OP_START, 8'h00); push_cmd(OP_WRITE, 8'hA2); push_cmd(OP_STOP, 8'h00);
    end
    pulse(1'b1, 1'b0);
    run_until_done(300, gap, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL nack_timeout: got timeout, required completion"); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL nack_err: got %b, required 1", err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL nack_busy: got %b, required 0", busy); end
    n_vec++; if (rtc !== prev) begin n_err++; $display("FAIL nack_rtc_held: got %h, required %h", rtc, prev); end
    n_vec++; if (n_strobe - base != 9) begin n_err++; $display("FAIL nack_strobes: got %0d, required 9", n_strobe - base); end
    nack_a2 = 1'b0;
    set_table(56'h42000901010226);
    push_read(13);
    pulse(1'b1, 1'b0);
    run_until_done(300, gap, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL clean_timeout: got timeout, required completion"); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL clean_err: got %b, required 0", err); end
    n_vec++; if (rtc !== 56'h42000901010226) begin n_err++; $display("FAIL clean_rtc: got %h, required 42000901010226", rtc); end
  endtask

  task automatic test_reset_mid_read();
    int gap, base;
    bit tmo, hit;
    set_table(56'h07080910030411);
    do_reset();
    push_read(9);
    base = n_strobe; hit = 1'b0;
    for (int c = 0; c < int'(POLL_DIV) + 100; c++) begin
      @(posedge mclk);
      #1;
      if (n_strobe - base >= 9) begin hit = 1'b1; break; end
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL mid_wait: got timeout, required 9 strobes"); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL mid_cmd_valid: got %b, required 0", bus.cmd_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b, required 0", busy); end
    n_vec++; if (rtc !== 56'h0) begin n_err++; $display("FAIL mid_rtc: got %h, required 0", rtc); end
    repeat (6) @(posedge mclk);
    @(negedge mclk);
    reset_n = 1'b1;
    push_read(13);
    run_until_done(int'(POLL_DIV) + 200, gap, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL mid_after_timeout: got timeout, required completion"); end
    n_vec++; if (rtc !== 56'h07080910030411) begin n_err++; $display("FAIL mid_after_rtc: got %h, required 07080910030411", rtc); end
    n_vec++; if (rtc_valid !== 1'b1) begin n_err++; $display("FAIL mid_after_valid: got %b, required 1", rtc_valid); end
  endtask

  initial begin
    test_reset();
    test_poll_read();
    test_set_write();
    test_back_to_back();
    test_poll_again();
    test_nack_retry();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
